pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//  Output-side companion to the input debouncer. Accepts one-cycle event
//  strobes from the CPU/SoC clock domain and turns each one into a
//  human/slow-device-visible pulse: ON_CYCLES high, then OFF_CYCLES low.
//  Events arriving while a pulse is in progress are queued in a saturating
//  counter and replayed in order. Drives LEDs, buzzers and slow external
//  strobes from 8051 port writes.
// PARAMETERS
//  ON_CYCLES   32'd25000000  high time per event, in i_clk cycles (>=1)
//  OFF_CYCLES  32'd25000000  mandatory low gap after each pulse (>=1)
//  PEND_W      3             pending-event counter width; max 2**PEND_W-1
// PORTS
//  i_clk       in   1       clock
//  i_rst       in   1       asynchronous reset, active-high
//  i_pulse     in   1       event strobe; every cycle sampled high = 1 event
//  o_signal    out  1       stretched output, registered
//  o_busy      out  1       1 when state != IDLE, registered
//  o_pending   out  PEND_W  queued events not yet started
//  o_overflow  out  1       sticky: an event was dropped (queue full)
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE, cnt=0, o_signal=0, o_busy=0,
//    o_pending=0, o_overflow=0; outputs change with no clock edge needed.
//  - FSM states IDLE, ON, OFF; cnt is a 32-bit cycle counter.
//  - IDLE: i_pulse=1 at edge t -> state ON, o_signal=1, o_busy=1, cnt=0
//    (1-cycle latency). i_pulse=0 -> stay IDLE.
//  - ON: cnt increments each edge; at the edge where cnt==ON_CYCLES-1 ->
//    state OFF, o_signal=0, cnt=0. o_signal is high exactly ON_CYCLES cycles.
//  - OFF: cnt increments; at the edge where cnt==OFF_CYCLES-1:
//      o_pending!=0 -> ON, o_signal=1, o_pending <= o_pending-1+i_pulse
//      else i_pulse=1 -> ON directly (no queue write, no IDLE cycle)
//      else -> IDLE, o_busy=0.
//  - i_pulse=1 in ON, or in OFF before its last cycle: o_pending+1; if
//    o_pending==2**PEND_W-1 the event is dropped, o_pending holds,
//    o_overflow<=1 (cleared only by reset).
//  - Simultaneous pulse + dequeue at OFF end: net pending unchanged; a
//    saturated queue does not set overflow in that cycle.
//  - Held i_pulse counts one event per high cycle (no edge detect).
//  - Counter compare uses full 32-bit width; no wrap in legal use.
// TESTING  (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2)
//  1. Single 1-cycle i_pulse from IDLE -> o_signal high cycles 1..4 after
//     strobe, low 5..7; o_busy high 7 cycles; o_pending stays 0.
//  2. Three strobes on consecutive cycles -> o_pending 1,2 then drains;
//     3 pulses of 4 high / 3 low; o_busy high 21 cycles continuous.
//  3. Six strobes during one ON -> o_pending saturates at 3, o_overflow=1,
//     exactly 4 total pulses emitted, overflow stays 1 after IDLE.
//  4. Strobe in the last OFF cycle, o_pending=0 -> o_signal=1 next cycle,
//     o_busy never drops, o_pending stays 0.
//  5. Strobe in last OFF cycle with o_pending=3 -> o_pending stays 3,
//     o_overflow stays 0, next ON starts.
//  6. Assert i_rst mid-ON between clock edges -> o_signal, o_busy,
//     o_pending, o_overflow go 0 immediately; after release, one strobe
//     gives a normal 4-cycle pulse.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event strobes into ON_CYCLES-high / OFF_CYCLES-low pulses,
// queueing events that arrive mid-pulse in a saturating pending counter.
`timescale 1ns/1ps
module pulse_stretcher #(
  parameter logic [31:0] ON_CYCLES  = 32'd25000000,
  parameter logic [31:0] OFF_CYCLES = 32'd25000000,
  parameter int unsigned PEND_W     = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pulse,
  output logic              o_signal,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              sig_q, busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_pulse) state_d = ON;
      end
      ON: begin
        if (cnt_q == ON_CYCLES - 32'd1) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        if (i_pulse) begin
          if (pend_q == PEND_MAX) ovf_d = 1'b1;
          else                    pend_d = pend_q + PEND_ONE;
        end
      end
      OFF: begin
        if (cnt_q == OFF_CYCLES - 32'd1) begin
          cnt_d = '0;
          // Dequeue and a new strobe in the same cycle cancel out, so a full
          // queue never reports overflow here.
          if (pend_q != '0) begin
            state_d = ON;
            pend_d  = pend_q - PEND_ONE + PEND_W'(i_pulse);
          end else if (i_pulse) begin
            state_d = ON;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (i_pulse) begin
            if (pend_q == PEND_MAX) ovf_d = 1'b1;
            else                    pend_d = pend_q + PEND_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      sig_q   <= (state_d == ON);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign o_signal   = sig_q;
  assign o_busy     = busy_q;
  assign o_pending  = pend_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a slot-position reference model queues
// the expected outputs per clock; a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_pulse_stretcher;

  localparam int ON_C   = 4;
  localparam int OFF_C  = 3;
  localparam int PW     = 2;
  localparam int PERIOD = ON_C + OFF_C;
  localparam int PMAX   = (1 << PW) - 1;

  typedef struct packed {
    logic          sig;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse = 1'b0;
  logic          o_signal, o_busy, o_overflow;
  logic [PW-1:0] o_pending;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Model: position inside the current ON+OFF slot (-1 = idle), pending count.
  int   m_pos = -1;
  int   m_pend = 0;
  bit   m_ovf = 1'b0;

  pulse_stretcher #(
    .ON_CYCLES (32'(ON_C)),
    .OFF_CYCLES(32'(OFF_C)),
    .PEND_W    (PW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_pulse   (pulse),
    .o_signal  (o_signal),
    .o_busy    (o_busy),
    .o_pending (o_pending),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_out();
    exp_t e;
    e.sig  = (m_pos >= 0) && (m_pos < ON_C);
    e.busy = (m_pos >= 0);
    e.pend = PW'(m_pend);
    e.ovf  = m_ovf;
    return e;
  endfunction

  task automatic model_step(input bit p);
    if (m_pos < 0) begin
      if (p) m_pos = 0;
    end else if (m_pos == PERIOD - 1) begin
      if (m_pend > 0) begin
        m_pos  = 0;
        m_pend = m_pend - 1 + int'(p);
      end else if (p) begin
        m_pos = 0;
      end else begin
        m_pos = -1;
      end
    end else begin
      m_pos++;
      if (p) begin
        if (m_pend == PMAX) m_ovf = 1'b1;
        else                m_pend++;
      end
    end
  endtask

  task automatic compare(input string name, input exp_t e);
    exp_t a;
    a = '{sig: o_signal, busy: o_busy, pend: o_pending, ovf: o_overflow};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t got sig=%b busy=%b pend=%0d ovf=%b want sig=%b busy=%b pend=%0d ovf=%b",
               name, $time, a.sig, a.busy, a.pend, a.ovf, e.sig, e.busy, e.pend, e.ovf);
    end
  endtask

  task automatic drive(input bit p);
    @(negedge clk);
    pulse = p;
    model_step(p);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  // Async reset between edges: outputs must clear before any clock edge.
  task automatic do_reset(input string name);
    @(posedge clk);
    #3;
    pulse = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_pos = -1; m_pend = 0; m_ovf = 1'b0;
    compare(name, model_out());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", e);
      end
    end
  end

  initial begin : stimulus
    int dens;
    #1;
    compare("reset_state", model_out());
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    drive(1'b1); idle(10);                                  // single strobe
    drive(1'b1); drive(1'b1); drive(1'b1); idle(25);        // back-to-back strobes
    drive(1'b1); for (int i = 0; i < 6; i++) drive(1'b1);   // saturate queue
    idle(40);
    drive(1'b1); idle(6); drive(1'b1); idle(12);            // strobe in last OFF, empty queue

    do_reset("reset_clears_ovf");
    drive(1'b1); drive(1'b1); drive(1'b1); drive(1'b1);     // pend=3
    idle(3); drive(1'b1); idle(40);                         // strobe in last OFF, full queue

    drive(1'b1); drive(1'b1); drive(1'b1); drive(1'b0);
    do_reset("reset_mid_on");
    drive(1'b1); idle(10);

    for (int blk = 0; blk < 16; blk++) begin
      case (blk % 4)
        0:       dens = 5;
        1:       dens = 20;
        2:       dens = 50;
        default: dens = 90;
      endcase
      for (int i = 0; i < 200; i++) drive($urandom_range(0, 99) < dens);
      if (blk == 9) do_reset("reset_random");
    end
    idle(40);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d queued entries want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
